// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

  localparam logic [1:0] CFG_MASK = 2'd0;
  localparam logic [1:0] CFG_PEND = 2'd1;
  localparam logic [1:0] CFG_BASE = 2'd2;
  localparam logic [1:0] CFG_STAT = 2'd3;

  localparam logic [7:0] VEC_BASE_RST = 8'hF0;

endpackage

// File: rtl/interrupt_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req_i,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = |req_i;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detected pending sources, enable mask, fixed
// priority selection and an IDLE/REQ/SERVICE handshake with the processor.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 8,
  parameter int VEC_SHIFT = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic [DATA_W-1:0]  cfg_rdata,
  output logic               irq,
  output logic [DATA_W-1:0]  irq_vector,
  input  logic               irq_ack,
  input  logic               iret,
  output logic               in_service
);

  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [DATA_W-1:0]  mask_q;
  logic [DATA_W-1:0]  base_q;
  irq_state_e         state_q;
  logic [ID_W-1:0]    id_q;
  logic               irq_q;
  logic               in_service_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] active;
  logic [ID_W-1:0]    sel_id;
  logic               sel_valid;
  logic               ack_take;

  assign rise     = irq_src & ~src_q;
  assign active   = pend_q & mask_q[NUM_SRC-1:0];
  assign ack_take = (state_q == REQ) && irq_ack;

  prio_enc #(.N(NUM_SRC), .ID_W(ID_W)) u_prio (
    .req_i   (active),
    .idx_o   (sel_id),
    .valid_o (sel_valid)
  );

  // Pending next state: clears (W1C and ack) first, then new edges so a set wins.
  always_comb begin
    w1c     = '0;
    ack_clr = '0;
    if (cfg_we && (cfg_addr == CFG_PEND)) w1c = cfg_wdata[NUM_SRC-1:0];
    if (ack_take) ack_clr[id_q] = 1'b1;
    pend_d = (pend_q & ~w1c & ~ack_clr) | rise;
  end

  // Source history, pending latch and writable config registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q  <= '0;
      pend_q <= '0;
      mask_q <= '0;
      base_q <= DATA_W'(VEC_BASE_RST);
    end else begin
      src_q  <= irq_src;
      pend_q <= pend_d;
      if (cfg_we && (cfg_addr == CFG_MASK)) mask_q <= cfg_wdata;
      if (cfg_we && (cfg_addr == CFG_BASE)) base_q <= cfg_wdata;
    end
  end

  // Handshake FSM with registered irq / in_service; id is frozen outside IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      id_q         <= '0;
      irq_q        <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            id_q    <= sel_id;
            state_q <= REQ;
            irq_q   <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state_q      <= SERVICE;
            irq_q        <= 1'b0;
            in_service_q <= 1'b1;
          end else if (!mask_q[id_q]) begin
            state_q <= IDLE;
            irq_q   <= 1'b0;
          end
        end
        SERVICE: begin
          if (iret) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_q        <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  logic [DATA_W-1:0] id_ext;
  assign id_ext     = DATA_W'(id_q);
  assign irq_vector = base_q + (id_ext << VEC_SHIFT);
  assign irq        = irq_q;
  assign in_service = in_service_q;

  // Combinational register read port.
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      CFG_MASK: cfg_rdata = mask_q;
      CFG_PEND: cfg_rdata = DATA_W'(pend_q);
      CFG_BASE: cfg_rdata = base_q;
      CFG_STAT: cfg_rdata = DATA_W'({state_q, in_service_q, 1'b0, 4'(id_q)});
      default:  cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench: stimulus pushes expected vectors, a monitor checks each irq rise.
module tb_interrupt_controller;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       irq;
  logic [7:0] irq_vector;
  logic       irq_ack;
  logic       iret;
  logic       in_service;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic irq_prev = 1'b0;

  interrupt_controller dut (
    .clk(clk), .reset(reset), .irq_src(irq_src),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .irq(irq), .irq_vector(irq_vector),
    .irq_ack(irq_ack), .iret(iret), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%02h", name, act);
    end
  endtask

  // Monitor: every irq rise must match the next queued vector.
  always @(negedge clk) begin
    if (irq === 1'b1 && irq_prev === 1'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_irq: got vector 0x%02h expected no request", irq_vector);
      end else begin
        check("irq_vector", irq_vector, exp_q.pop_front());
      end
    end
    irq_prev <= (irq === 1'b1);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc(1);
    cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input string name, input logic [1:0] a, input logic [7:0] exp);
    cfg_addr = a;
    #1;
    check(name, cfg_rdata, exp);
  endtask

  task automatic pulse_src(input logic [3:0] s);
    irq_src = s;
    cyc(1);
    irq_src = 4'h0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1; cyc(1); irq_ack = 1'b0;
  endtask

  task automatic do_iret();
    iret = 1'b1; cyc(1); iret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq_src = 4'h0; cfg_we = 1'b0; cfg_addr = 2'd0;
    cfg_wdata = 8'h00; irq_ack = 1'b0; iret = 1'b0;
    cyc(2);
    reset = 1'b0;
    // Reset state
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_in_service", {7'b0, in_service}, 8'h00);
    check("rst_vector", irq_vector, 8'hF0);
    cfg_read("rst_mask", CFG_MASK, 8'h00);
    cfg_read("rst_pend", CFG_PEND, 8'h00);
    cfg_read("rst_base", CFG_BASE, 8'hF0);
    cfg_read("rst_stat", CFG_STAT, 8'h00);

    // 1: single source, two-cycle latency, ack then iret
    cfg_write(CFG_MASK, 8'h0F);
    exp_q.push_back(8'hF8);
    pulse_src(4'b0100);
    check("t1_irq_after_1", {7'b0, irq}, 8'h00);
    cyc(1);
    check("t1_irq_after_2", {7'b0, irq}, 8'h01);
    cfg_read("t1_stat_req", CFG_STAT, 8'h42);
    do_ack();
    check("t1_irq_after_ack", {7'b0, irq}, 8'h00);
    check("t1_in_service", {7'b0, in_service}, 8'h01);
    cfg_read("t1_stat_srv", CFG_STAT, 8'hA2);
    cfg_read("t1_pend_clr", CFG_PEND, 8'h00);
    do_iret();
    cfg_read("t1_stat_idle", CFG_STAT, 8'h02);

    // 2: simultaneous src[3] and src[1], priority then second request
    exp_q.push_back(8'hF4);
    exp_q.push_back(8'hFC);
    pulse_src(4'b1010);
    cyc(1);
    check("t2_irq", {7'b0, irq}, 8'h01);
    cfg_read("t2_pend", CFG_PEND, 8'h0A);
    do_ack();
    do_iret();
    check("t2_gap_idle", {7'b0, irq}, 8'h00);
    cyc(1);
    check("t2_irq_again", {7'b0, irq}, 8'h01);
    do_ack();
    do_iret();

    // 3: masked source stays pending, unmask raises irq one cycle later
    cfg_write(CFG_MASK, 8'h00);
    pulse_src(4'b0001);
    cyc(3);
    check("t3_no_irq", {7'b0, irq}, 8'h00);
    cfg_read("t3_stat", CFG_STAT, 8'h03);
    cfg_read("t3_pend", CFG_PEND, 8'h01);
    exp_q.push_back(8'hF0);
    cfg_write(CFG_MASK, 8'h01);
    check("t3_irq_not_yet", {7'b0, irq}, 8'h00);
    cyc(1);
    check("t3_irq", {7'b0, irq}, 8'h01);
    do_ack();
    do_iret();

    // 4: mask drop in REQ withdraws irq but keeps pending
    cfg_write(CFG_MASK, 8'h0F);
    exp_q.push_back(8'hF4);
    pulse_src(4'b0010);
    cyc(1);
    check("t4_irq", {7'b0, irq}, 8'h01);
    cfg_write(CFG_MASK, 8'h0D);
    cyc(1);
    check("t4_irq_dropped", {7'b0, irq}, 8'h00);
    cfg_read("t4_stat", CFG_STAT, 8'h01);
    cfg_read("t4_pend_kept", CFG_PEND, 8'h02);
    cfg_write(CFG_PEND, 8'h02);
    cfg_read("t4_pend_w1c", CFG_PEND, 8'h00);
    cyc(3);

    // Set wins over a same-cycle W1C clear
    cfg_write(CFG_MASK, 8'h00);
    irq_src = 4'b0001;
    cfg_write(CFG_PEND, 8'h01);
    cfg_read("setwins_pend", CFG_PEND, 8'h01);
    irq_src = 4'h0;
    cfg_write(CFG_PEND, 8'h01);
    cfg_read("w1c_pend", CFG_PEND, 8'h00);

    // 5: vector wraparound, stray ack/iret in IDLE, ack+iret together in REQ
    cfg_write(CFG_BASE, 8'hFE);
    cfg_write(CFG_MASK, 8'h0F);
    irq_ack = 1'b1; iret = 1'b1;
    cyc(1);
    irq_ack = 1'b0; iret = 1'b0;
    cfg_read("t5_stat_idle", CFG_STAT, 8'h01);
    check("t5_in_service", {7'b0, in_service}, 8'h00);
    exp_q.push_back(8'h02);
    pulse_src(4'b0010);
    cyc(1);
    check("t5_irq", {7'b0, irq}, 8'h01);
    irq_ack = 1'b1; iret = 1'b1;
    cyc(1);
    irq_ack = 1'b0; iret = 1'b0;
    check("t5_ack_iret_srv", {7'b0, in_service}, 8'h01);

    // 6: reset in SERVICE with a pending source
    pulse_src(4'b0001);
    cfg_read("t6_pend_pre", CFG_PEND, 8'h01);
    reset = 1'b1;
    cyc(1);
    check("t6_in_service", {7'b0, in_service}, 8'h00);
    check("t6_irq", {7'b0, irq}, 8'h00);
    check("t6_vector", irq_vector, 8'hF0);
    cfg_read("t6_pend", CFG_PEND, 8'h00);
    reset = 1'b0;
    cyc(4);
    check("t6_no_irq", {7'b0, irq}, 8'h00);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
